jregfile: RTL

//  Parametrised clocked register file for the jcscpu datapath: N registers of W bits on one shared tri-state bus.

---
 rtl/jregfile_pkg.sv | 10 +
 rtl/jregfile_if.sv | 12 +
 rtl/jregfile_register.sv | 10 +
 rtl/jregfile.sv | 47 ++++
 4 files changed

// File: rtl/jregfile_pkg.sv
// jregfile_pkg: default sizes and the address-width helper for the register file
package jregfile_pkg;
  localparam int JCS_W = 8;
  localparam int JCS_N = 4;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/jregfile_if.sv
// jregfile_if: control, address and tap signals of the register file
interface jregfile_if #(parameter int W = 8, parameter int A = 2);
  logic         wset;
  logic [A-1:0] wsa;
  logic         wena;
  logic [A-1:0] wea;
  logic [A-1:0] wta;
  logic [W-1:0] btap;
  logic         wbusy;
  modport master(output wset, wsa, wena, wea, wta, input btap, wbusy);
  modport slave(input wset, wsa, wena, wea, wta, output btap, wbusy);
endinterface

// File: rtl/jregfile_register.sv
// jregfile_register: one W-bit flop bank with synchronous clear and load enable
module jregfile_register #(parameter int W = 8) (
  input  logic         wclk,
  input  logic         wreset,
  input  logic         wset,
  input  logic [W-1:0] bis,
  output logic [W-1:0] bos
);
  always_ff @(posedge wclk) bos <= wreset ? '0 : wset ? bis : bos;
endmodule

// File: rtl/jregfile.sv
// jregfile: N x W register file loading from and driving one shared tri-state bus
module jregfile
  import jregfile_pkg::*;
#(
  parameter int W = JCS_W,
  parameter int N = JCS_N,
  parameter int A = 2
) (
  input  logic         wclk,
  input  logic         wreset,
  inout  wire  [W-1:0] bbus,
  jregfile_if.slave    bus
);
  if (W < 2 || N < 2 || (1 << A) != N || A != clog2(N)) begin : g_bad_param
    $error("jregfile: W must be >= 2 and A must equal log2(N)");
  end
  logic [N-1:0]        sel_s;
  logic [N-1:0]        sel_e;
  logic [N-1:0][W-1:0] regs;
  logic [W-1:0]        drive;
  logic [W-1:0]        tap;
  // decoded selects gate each register onto an AND-OR mux; only one is ever hot
  always_comb begin
    sel_s = '0;
    sel_e = '0;
    drive = '0;
    tap   = '0;
    for (int i = 0; i < N; i++) begin
      sel_s[i] = bus.wset && bus.wsa == A'(i);
      sel_e[i] = bus.wena && bus.wea == A'(i);
      drive    = drive | (regs[i] & {W{sel_e[i]}});
      tap      = tap | (regs[i] & {W{bus.wta == A'(i)}});
    end
  end
  for (genvar g = 0; g < N; g++) begin : g_reg
    jregfile_register #(.W(W)) u_reg (
      .wclk  (wclk),
      .wreset(wreset),
      .wset  (sel_s[g]),
      .bis   (bbus),
      .bos   (regs[g])
    );
  end
  assign bbus      = bus.wena ? drive : 'z;
  assign bus.btap  = tap;
  assign bus.wbusy = bus.wena;
endmodule
